// File: rtl/pixel_sensor_ctrl_pkg.sv
// Purpose : shared types and default phase lengths for the pixel row sequencer.
// Latency : n/a (types, constants and one helper function only).
// Backpressure : n/a.
package PixelSensorConfig;

  // Default phase lengths, in clock cycles.
  localparam int C_ERASE   = 5;
  localparam int C_CONVERT = 255;  // final ramp value; CONVERT lasts C_CONVERT+1 cycles
  localparam int C_READ    = 5;

  localparam int PIXEL_ARRAY_WIDTH = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_GAP,
    ST_EXPOSE,
    ST_CONVERT,
    ST_READ
  } ctrl_state_t;

  // Converts a phase length in cycles into the phase_timer load value.
  // Timers count len-1 down to 0, so a length of 0 is treated as 1.
  function automatic logic [7:0] len_to_load(input logic [7:0] len);
    return (len == 8'd0) ? 8'd0 : len - 8'd1;
  endfunction

endpackage

// File: rtl/pixel_sensor_ctrl_phase_timer.sv
// Purpose : 8-bit down-counter loaded on phase entry; flags terminal count.
// Latency : tc is registered-state based; tc_next gives the value tc will have next cycle.
// Backpressure : none; free-running once loaded, holds at zero.
//
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   load, load_val  load load_val on this posedge (phase length minus one)
//   tc              count is zero: current cycle is the last cycle of the phase
//   tc_next         count will be zero after this posedge
module phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       tc,
  output logic       tc_next
);

  logic [7:0] count;
  logic [7:0] count_next;

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (count != 8'd0) begin
      count_next = count - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else begin
      count <= count_next;
    end
  end

  assign tc      = (count == 8'd0);
  assign tc_next = (count_next == 8'd0);

endmodule

// File: rtl/pixel_sensor_ctrl.sv
// Purpose : sequences ERASE/EXPOSE/CONVERT/READ for one pixel row, with a one-cycle
//           all-low GAP between phases, an 8-bit ramp counter and capture/done pulses.
// Latency : ERASE starts the cycle after start is sampled; all outputs are registered.
// Backpressure : none; start is only honoured in IDLE, otherwise ignored.
//
// Optional feature macro: PIXEL_CTRL_CONTINUOUS_EN adds input stop and repeats
// frames back-to-back until stop has been seen.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset (forces IDLE, outputs 0)
//   start             request one frame (IDLE only)
//   expose_cycles     exposure length, latched on ERASE entry (0 behaves as 1)
//   stop              (continuous build only) finish the current frame, then idle
//   erase/expose/read phase controls to the pixel row, at most one high
//   ramp_en, bias_en  ramp gate (CONVERT) and bias gate (same as expose)
//   counter           digital ramp, 0 outside CONVERT
//   row_capture       pulse on the last READ cycle
//   frame_done        pulse in the GAP after READ
//   busy              high whenever not in IDLE
module pixel_sensor_ctrl #(
  parameter int C_ERASE   = PixelSensorConfig::C_ERASE,
  parameter int C_CONVERT = PixelSensorConfig::C_CONVERT,
  parameter int C_READ    = PixelSensorConfig::C_READ
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] expose_cycles,
`ifdef PIXEL_CTRL_CONTINUOUS_EN
  input  logic       stop,
`endif
  output logic       erase,
  output logic       expose,
  output logic       read,
  output logic       ramp_en,
  output logic       bias_en,
  output logic [7:0] counter,
  output logic       row_capture,
  output logic       frame_done,
  output logic       busy
);

  import PixelSensorConfig::*;

  localparam logic [7:0] ERASE_LOAD = 8'(C_ERASE - 1);
  localparam logic [7:0] READ_LOAD  = 8'(C_READ - 1);
  localparam logic [7:0] RAMP_LAST  = 8'(C_CONVERT);

  ctrl_state_t state, state_next;
  ctrl_state_t gap_succ, gap_succ_next;   // where the current GAP leads
  logic [7:0]  exp_len;                   // exposure length latched for this frame
  logic [7:0]  counter_next;
  logic        frame_end;
  logic        timer_load;
  logic [7:0]  timer_val;
  logic        timer_tc;
  logic        timer_tc_next;

`ifdef PIXEL_CTRL_CONTINUOUS_EN
  logic stop_flag;
`endif

  phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (timer_tc),
    .tc_next  (timer_tc_next)
  );

  // Next-state logic.
  always_comb begin
    state_next    = state;
    gap_succ_next = gap_succ;
    frame_end     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_ERASE;
      end
      ST_ERASE: begin
        if (timer_tc) begin
          state_next    = ST_GAP;
          gap_succ_next = ST_EXPOSE;
        end
      end
      ST_EXPOSE: begin
        if (timer_tc) begin
          state_next    = ST_GAP;
          gap_succ_next = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (counter == RAMP_LAST) begin
          state_next    = ST_GAP;
          gap_succ_next = ST_READ;
        end
      end
      ST_READ: begin
        if (timer_tc) begin
          state_next = ST_GAP;
          frame_end  = 1'b1;
`ifdef PIXEL_CTRL_CONTINUOUS_EN
          gap_succ_next = ST_ERASE;
`else
          gap_succ_next = ST_IDLE;
`endif
        end
      end
      ST_GAP: begin
        state_next = gap_succ;
`ifdef PIXEL_CTRL_CONTINUOUS_EN
        // Only the post-READ GAP leads to ERASE; a pending stop ends the run here.
        if (gap_succ == ST_ERASE && (stop_flag || stop)) state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Timer is loaded on entry to each timed phase.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = 8'd0;
    if (state_next != state) begin
      case (state_next)
        ST_ERASE: begin
          timer_load = 1'b1;
          timer_val  = ERASE_LOAD;
        end
        ST_EXPOSE: begin
          timer_load = 1'b1;
          timer_val  = len_to_load(exp_len);
        end
        ST_READ: begin
          timer_load = 1'b1;
          timer_val  = READ_LOAD;
        end
        default: ;
      endcase
    end
  end

  // Ramp restarts at 0 on CONVERT entry and is 0 everywhere else.
  always_comb begin
    counter_next = 8'd0;
    if (state_next == ST_CONVERT && state == ST_CONVERT) begin
      counter_next = counter + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      gap_succ <= ST_IDLE;
      exp_len  <= 8'd0;
    end else begin
      state    <= state_next;
      gap_succ <= gap_succ_next;
      // ERASE entry is start acceptance in single-shot mode and also every
      // frame restart in continuous mode, so one condition covers both.
      if (state_next == ST_ERASE && state != ST_ERASE) begin
        exp_len <= expose_cycles;
      end
    end
  end

`ifdef PIXEL_CTRL_CONTINUOUS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stop_flag <= 1'b0;
    end else if (state_next == ST_IDLE) begin
      stop_flag <= 1'b0;
    end else if (stop) begin
      stop_flag <= 1'b1;
    end
  end
`endif

  // Outputs are registered from the next state so they align with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      erase       <= 1'b0;
      expose      <= 1'b0;
      read        <= 1'b0;
      ramp_en     <= 1'b0;
      bias_en     <= 1'b0;
      counter     <= 8'd0;
      row_capture <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      erase       <= (state_next == ST_ERASE);
      expose      <= (state_next == ST_EXPOSE);
      bias_en     <= (state_next == ST_EXPOSE);
      ramp_en     <= (state_next == ST_CONVERT);
      read        <= (state_next == ST_READ);
      counter     <= counter_next;
      // Last READ cycle is the one in which the timer will sit at zero.
      row_capture <= (state_next == ST_READ) && timer_tc_next;
      frame_done  <= frame_end;
      busy        <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// Purpose : scoreboard bench for pixel_sensor_ctrl (default single-shot build).
// Latency : expected phase/frame cycles are derived from the start-sampling edge.
// Backpressure : n/a.
module tb_pixel_sensor_ctrl;

  localparam int CE = 5;
  localparam int CC = 255;
  localparam int CR = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] expose_cycles = 8'd0;
`ifdef PIXEL_CTRL_CONTINUOUS_EN
  logic       stop = 1'b0;
`endif
  logic       erase, expose, read, ramp_en, bias_en;
  logic [7:0] counter;
  logic       row_capture, frame_done, busy;

  pixel_sensor_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .expose_cycles (expose_cycles),
`ifdef PIXEL_CTRL_CONTINUOUS_EN
    .stop          (stop),
`endif
    .erase         (erase),
    .expose        (expose),
    .read          (read),
    .ramp_en       (ramp_en),
    .bias_en       (bias_en),
    .counter       (counter),
    .row_capture   (row_capture),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  // Scoreboard queues: absolute cyc values (or lengths) expected from the DUT.
  int exp_erase[$];
  int exp_expose[$];
  int exp_cap[$];
  int exp_done[$];

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
    end
  endfunction

  // s = cyc value seen during cycle 1 of the frame; cycle k is seen at cyc s+k-1.
  function automatic void push_frame(input int s, input int e);
    int el;
    el = (e == 0) ? 1 : e;
    exp_erase.push_back(s);
    exp_expose.push_back(el);
    exp_cap.push_back(s + CE + el + CC + CR + 5 - 2);
    exp_done.push_back(s + CE + el + CC + CR + 5 - 1);
  endfunction

  // Monitor: samples on the falling edge, pops expectations as events appear.
  logic [3:0] prev_ph = 4'd0;
  logic       prev_done = 1'b0;
  logic [7:0] last_cnt = 8'd0;
  int erase_len = 0, expose_len = 0, ramp_len = 0, read_len = 0;

  always @(negedge clk) begin
    logic [3:0] ph;
    ph = {erase, expose, ramp_en, read};
    if (reset) begin
      prev_ph = 4'd0; prev_done = 1'b0;
      erase_len = 0; expose_len = 0; ramp_len = 0; read_len = 0;
    end else begin
      chk("phase_onehot", ($countones(ph) > 1) ? 1 : 0, 0);
      chk("bias_eq_expose", int'(bias_en), int'(expose));
      if (!ramp_en) chk("counter_zero_outside", int'(counter), 0);
      chk("break_before_make", (ph != 4'd0 && prev_ph != 4'd0 && ph != prev_ph) ? 1 : 0, 0);

      if (erase && !prev_ph[3]) begin
        if (exp_erase.size() == 0) chk("erase_unexpected", 1, 0);
        else chk("erase_start_cyc", cyc, exp_erase.pop_front());
      end
      if (erase) erase_len++;
      else if (prev_ph[3]) begin chk("erase_len", erase_len, CE); erase_len = 0; end

      if (expose) expose_len++;
      else if (prev_ph[2]) begin
        if (exp_expose.size() == 0) chk("expose_unexpected", 1, 0);
        else chk("expose_len", expose_len, exp_expose.pop_front());
        expose_len = 0;
      end

      if (ramp_en) begin
        chk("counter_ramp", int'(counter), ramp_len);
        ramp_len++;
        last_cnt = counter;
      end else if (prev_ph[1]) begin
        chk("convert_len", ramp_len, CC + 1);
        chk("counter_last", int'(last_cnt), CC);
        ramp_len = 0;
      end

      if (read) read_len++;
      else if (prev_ph[0]) begin chk("read_len", read_len, CR); read_len = 0; end

      if (row_capture) begin
        chk("capture_with_read", int'(read), 1);
        if (exp_cap.size() == 0) chk("capture_unexpected", 1, 0);
        else chk("capture_cyc", cyc, exp_cap.pop_front());
      end
      if (frame_done) begin
        done_cnt++;
        if (exp_done.size() == 0) chk("frame_done_unexpected", 1, 0);
        else chk("frame_done_cyc", cyc, exp_done.pop_front());
      end
      if (prev_done) chk("busy_after_done", int'(busy), 0);

      prev_done = frame_done;
      prev_ph = ph;
    end
  end

  task automatic do_start(input int e, output int s);
    @(negedge clk);
    expose_cycles = e[7:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    start = 1'b0;
    push_frame(s, e);
    @(negedge clk);
    chk("busy_cycle1", int'(busy), 1);
    chk("erase_cycle1", int'(erase), 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_done.size() != 0) && n < 2000);
    chk({name, "_idle_timeout"}, (n >= 2000) ? 1 : 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_erase", int'(erase), 0);
    chk("rst_expose", int'(expose), 0);
    chk("rst_read", int'(read), 0);
    chk("rst_ramp_en", int'(ramp_en), 0);
    chk("rst_bias_en", int'(bias_en), 0);
    chk("rst_counter", int'(counter), 0);
    chk("rst_row_capture", int'(row_capture), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_without_start", int'(busy), 0);

    // Frame A: full exposure, frame_done expected in cycle 525.
    do_start(255, s);
    chk("frame_a_done_rel_cycle", exp_done[0] - s + 1, 525);
    wait_idle("frame_a");
    chk("done_count_a", done_cnt, 1);

    // Frame B: zero exposure clamps to 1; start during CONVERT is ignored.
    do_start(0, s);
    n = 0;
    while (!ramp_en && n < 1000) begin @(negedge clk); n++; end
    chk("b_reached_convert", int'(ramp_en), 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("frame_b");
    chk("done_count_b", done_cnt, 2);

    // Frame C: exposure 3, input changed mid-frame; then earliest re-start (frame D).
    do_start(3, s);
    expose_cycles = 8'd10;
    n = 0;
    while (!frame_done && n < 2000) begin @(negedge clk); n++; end
    chk("c_frame_done_seen", int'(frame_done), 1);
    start = 1'b1;
    expose_cycles = 8'd2;
    @(posedge clk);   // GAP -> IDLE, start not yet honoured
    @(posedge clk);   // sampled in first IDLE cycle
    #1;
    s = cyc;
    start = 1'b0;
    push_frame(s, 2);
    wait_idle("frame_d");
    chk("done_count_d", done_cnt, 4);

    // Frame E: reset asserted in cycle 300 (inside CONVERT) aborts the frame.
    do_start(255, s);
    while (cyc < s + 299) @(negedge clk);
    #2;
    chk("ramp_before_abort", int'(ramp_en), 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ramp_en", int'(ramp_en), 0);
    chk("abort_counter", int'(counter), 0);
    chk("abort_phases", int'({erase, expose, read, bias_en}), 0);
    chk("abort_pending_expose", exp_expose.size(), 0);
    exp_done.delete();
    exp_cap.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_abort_idle", int'(busy), 0);
    chk("post_abort_done_count", done_cnt, 4);

    // Frame F: block restarts normally after the abort.
    do_start(1, s);
    wait_idle("frame_f");
    chk("done_count_f", done_cnt, 5);
    chk("left_erase", exp_erase.size(), 0);
    chk("left_expose", exp_expose.size(), 0);
    chk("left_capture", exp_cap.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_sensor_ctrl.md
# pixel_sensor_ctrl

Synthesizable sequencer that drives one `PIXEL_ROW`. It generates the ERASE, EXPOSE, CONVERT and READ phase controls, the 8-bit digital ramp on COUNTER, and the ramp and bias enables. It sits directly upstream of the pixel row. It replaces the behavioural state machine used around the row in simulation, and it signals downstream logic when `DATA_OUT` is valid to capture.

## Interface
Parameters:
- `C_ERASE`, 5: ERASE phase length in cycles (≥1).
- `C_CONVERT`, 255: final ramp value; CONVERT lasts `C_CONVERT+1` cycles (≤255).
- `C_READ`, 5: READ phase length in cycles (≥1).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-high; forces idle.
- `start` in 1: request one frame; sampled only in IDLE.
- `expose_cycles` in 8: exposure length; latched when `start` is accepted.
- `erase` out 1: to `PIXEL_ROW.ERASE`.
- `expose` out 1: to `PIXEL_ROW.EXPOSE`.
- `read` out 1: to `PIXEL_ROW.READ`.
- `ramp_en` out 1: high during CONVERT; top level gates RAMP with it.
- `bias_en` out 1: equals `expose`; top level gates VBN1 with it.
- `counter` out 8: digital ramp, to `PIXEL_ROW.COUNTER`.
- `row_capture` out 1: one-cycle pulse on the last READ cycle.
- `frame_done` out 1: one-cycle pulse after a frame completes.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, ERASE, GAP, EXPOSE, CONVERT, READ. GAP is one cycle with all phase controls low, inserted between every pair of phases (break-before-make).
- Transitions:
  - IDLE→ERASE when `start`=1 at a posedge.
  - ERASE→GAP→EXPOSE→GAP→CONVERT→GAP→READ→GAP→IDLE.
  - GAP remembers its successor state.
- Phase control outputs:
  - `erase`=1 only in ERASE.
  - `expose`=`bias_en`=1 only in EXPOSE.
  - `ramp_en`=1 only in CONVERT.
  - `read`=1 only in READ.
  - All outputs are registered, and at most one phase control is high in any cycle.
- Counter:
  - `counter`=0 outside CONVERT.
  - On CONVERT entry `counter`=0, then +1 per cycle up to `C_CONVERT`; leave CONVERT on the cycle `counter`==`C_CONVERT`.
  - 8-bit, never wraps.
- Exposure length: EXPOSE lasts `max(expose_cycles_latched,1)` cycles; a value of 0 is clamped to 1.
- `start` while `busy` is ignored. Changes to `expose_cycles` after acceptance have no effect on the current frame.
- `frame_done` pulses in the GAP cycle following READ.
- Reset: values during reset and after release:
  - state=IDLE;
  - every output 0;
  - latched exposure=0.
- Reset mid-frame aborts immediately; no `frame_done`. After release, remain in IDLE until `start`.

## Timing
- Number cycles so that the first cycle after the posedge that samples `start` is cycle 1.
- Phase windows:
  - `erase` high in cycles 1..C_ERASE.
  - EXPOSE begins at cycle C_ERASE+2 and runs E = clamped exposure cycles.
  - CONVERT begins at C_ERASE+E+3 and runs C_CONVERT+1 cycles.
  - READ begins at C_ERASE+E+C_CONVERT+5.
- `frame_done` cycle = C_ERASE+E+C_CONVERT+C_READ+5. With defaults and E=255 this is cycle 525.
- `busy` rises in cycle 1 and falls in the cycle after `frame_done` (IDLE).
- `row_capture` coincides with the last `read`=1 cycle; downstream latches `DATA_OUT` on the following posedge.
- Earliest re-start: `start` sampled in the first IDLE cycle begins the next ERASE one cycle later.

## Configuration
- `PIXEL_CTRL_CONTINUOUS_EN` defined:
  - Adds input `stop` (1 bit).
  - The GAP after READ goes to ERASE instead of IDLE, so frames repeat without `start`. `frame_done` still pulses each frame and `busy` stays 1.
  - `stop`=1 at any posedge sets a sticky flag. The current frame completes normally, then the block goes to IDLE and the flag clears.
  - `expose_cycles` is re-latched at each ERASE entry.
- Not defined: no `stop` port; single-shot behaviour as in Operation.

## Structure
- Shared package `PixelSensorConfig` holds:
  - the state enum typedef `ctrl_state_t`;
  - the default phase constants `C_ERASE`, `C_CONVERT`, `C_READ`;
  - `PIXEL_ARRAY_WIDTH`.
- One sub-module, `phase_timer`: an 8-bit down-counter loaded on phase entry that outputs a terminal-count flag. The FSM uses it for ERASE, EXPOSE and READ. CONVERT uses the up-counting `counter` directly.

## Test plan
- Reset, then pulse `start` with `expose_cycles`=255 and defaults → `erase` high cycles 1–5; `counter` reaches 255 on the last CONVERT cycle; `frame_done` in cycle 525 only.
- Every cycle of a frame → at most one of `erase`/`expose`/`ramp_en`/`read` high; a zero cycle exists between every pair of phases; `bias_en`==`expose` and `counter`==0 outside CONVERT.
- `expose_cycles`=0 → EXPOSE exactly 1 cycle. `expose_cycles` changed to 10 mid-frame → current EXPOSE length unchanged.
- `start` pulsed during CONVERT → ignored; `frame_done` count stays 1.
- `reset` asserted in cycle 300 → all outputs 0 asynchronously; no `frame_done`; after release the block stays idle until `start`.
- With `PIXEL_CTRL_CONTINUOUS_EN`: one `start` → three back-to-back frames, each with `frame_done`. `stop` during frame 3 → frame 3 completes, then `busy`=0.
